// File: rtl/lagarto_fpu_fflags_acc_if.sv
// Signal bundle between the FP writeback/commit side and the fflags accumulator.
// master = issue/writeback/commit/CSR side, slave = accumulator.
interface lagarto_fpu_fflags_acc_if #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_LANES   = 4
);
  localparam int TAG_W = $clog2(NUM_ENTRIES);

  logic                       alloc_valid_i;
  logic [TAG_W-1:0]           alloc_tag_i;
  logic [NUM_LANES-1:0]       rep_valid_i;
  logic [NUM_LANES*TAG_W-1:0] rep_tag_i;
  logic [NUM_LANES*5-1:0]     rep_flags_i;
  logic                       commit_valid_i;
  logic [TAG_W-1:0]           commit_tag_i;
  logic                       kill_valid_i;
  logic [TAG_W-1:0]           kill_tag_i;
  logic                       flush_i;
  logic                       csr_we_i;
  logic [4:0]                 csr_wdata_i;
  logic [4:0]                 fflags_o;
  logic                       commit_flags_valid_o;
  logic [4:0]                 commit_flags_o;
  logic                       fs_dirty_o;
  logic                       err_o;

  modport master (
    output alloc_valid_i, alloc_tag_i, rep_valid_i, rep_tag_i, rep_flags_i,
           commit_valid_i, commit_tag_i, kill_valid_i, kill_tag_i, flush_i,
           csr_we_i, csr_wdata_i,
    input  fflags_o, commit_flags_valid_o, commit_flags_o, fs_dirty_o, err_o
  );

  modport slave (
    input  alloc_valid_i, alloc_tag_i, rep_valid_i, rep_tag_i, rep_flags_i,
           commit_valid_i, commit_tag_i, kill_valid_i, kill_tag_i, flush_i,
           csr_we_i, csr_wdata_i,
    output fflags_o, commit_flags_valid_o, commit_flags_o, fs_dirty_o, err_o
  );
endinterface

// File: rtl/lagarto_fpu_fflags_acc.sv
// Speculative per-tag FP exception flag accumulator; merges into fflags 1 cycle after commit, never stalls.
// Define LAGARTO_FFLAGS_CHECK_EN to enable the sticky protocol error output err_o.
module lagarto_fpu_fflags_acc #(
  parameter int NUM_ENTRIES = 8,
  parameter int NUM_LANES   = 4
) (
  input logic                   clk_i,
  input logic                   rstn_i,
  lagarto_fpu_fflags_acc_if.slave bus
);
  localparam int TAG_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [4:0]             pend_q  [NUM_ENTRIES];
  logic [4:0]             pend_d  [NUM_ENTRIES];
  logic [4:0]             rep_hit [NUM_ENTRIES];

  logic [4:0] fflags_q, fflags_d;
  logic [4:0] cflags;
  logic [4:0] commit_flags_q;
  logic       commit_valid_q;
  logic       dirty_q;
  logic       commit_kept;

  // Same-cycle reports per entry, OR-ed across lanes.
  always_comb begin
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      rep_hit[e] = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
        if (bus.rep_valid_i[k] && (bus.rep_tag_i[k*TAG_W +: TAG_W] == TAG_W'(e)))
          rep_hit[e] = rep_hit[e] | bus.rep_flags_i[k*5 +: 5];
      end
    end
  end

  // A flush or a kill of the same tag wins over the commit.
  assign commit_kept = bus.commit_valid_i && !bus.flush_i &&
                       !(bus.kill_valid_i && (bus.kill_tag_i == bus.commit_tag_i));

  assign cflags = valid_q[bus.commit_tag_i] ?
                  (pend_q[bus.commit_tag_i] | rep_hit[bus.commit_tag_i]) : 5'b0;

  // Retire actions first, alloc last so a retired tag comes back clean.
  always_comb begin
    for (int e = 0; e < NUM_ENTRIES; e++) begin
      valid_d[e] = valid_q[e];
      pend_d[e]  = valid_q[e] ? (pend_q[e] | rep_hit[e]) : pend_q[e];
      if (commit_kept && (bus.commit_tag_i == TAG_W'(e))) begin
        valid_d[e] = 1'b0;
        pend_d[e]  = '0;
      end
      if (bus.kill_valid_i && (bus.kill_tag_i == TAG_W'(e))) begin
        valid_d[e] = 1'b0;
        pend_d[e]  = '0;
      end
      if (bus.flush_i) begin
        valid_d[e] = 1'b0;
        pend_d[e]  = '0;
      end
      if (bus.alloc_valid_i && (bus.alloc_tag_i == TAG_W'(e))) begin
        valid_d[e] = 1'b1;
        pend_d[e]  = '0;
      end
    end
  end

  // Software write is younger than the retiring instruction, so it wins.
  always_comb begin
    fflags_d = fflags_q;
    if (bus.csr_we_i)
      fflags_d = bus.csr_wdata_i;
    else if (commit_kept)
      fflags_d = fflags_q | cflags;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q        <= '0;
      fflags_q       <= '0;
      commit_flags_q <= '0;
      commit_valid_q <= 1'b0;
      dirty_q        <= 1'b0;
      for (int e = 0; e < NUM_ENTRIES; e++) pend_q[e] <= '0;
    end else begin
      valid_q        <= valid_d;
      fflags_q       <= fflags_d;
      commit_flags_q <= commit_kept ? cflags : 5'b0;
      commit_valid_q <= commit_kept;
      dirty_q        <= (fflags_d != fflags_q);
      for (int e = 0; e < NUM_ENTRIES; e++) pend_q[e] <= pend_d[e];
    end
  end

  assign bus.fflags_o             = fflags_q;
  assign bus.commit_flags_o       = commit_flags_q;
  assign bus.commit_flags_valid_o = commit_valid_q;
  assign bus.fs_dirty_o           = dirty_q;

`ifdef LAGARTO_FFLAGS_CHECK_EN
  logic err_q;
  logic err_hit;
  logic alloc_freed;

  always_comb begin
    err_hit     = 1'b0;
    alloc_freed = bus.flush_i ||
                  (bus.kill_valid_i && (bus.kill_tag_i == bus.alloc_tag_i)) ||
                  (bus.commit_valid_i && (bus.commit_tag_i == bus.alloc_tag_i));
    for (int k = 0; k < NUM_LANES; k++) begin
      if (bus.rep_valid_i[k] && !valid_q[bus.rep_tag_i[k*TAG_W +: TAG_W]])
        err_hit = 1'b1;
    end
    if (bus.commit_valid_i && !valid_q[bus.commit_tag_i]) err_hit = 1'b1;
    if (bus.kill_valid_i && !valid_q[bus.kill_tag_i])     err_hit = 1'b1;
    if (bus.alloc_valid_i && valid_q[bus.alloc_tag_i] && !alloc_freed)
      err_hit = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) err_q <= 1'b0;
    else         err_q <= err_q | err_hit;
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_lagarto_fpu_fflags_acc.sv
// Directed stimulus with a commit-output scoreboard for lagarto_fpu_fflags_acc.
module tb_lagarto_fpu_fflags_acc;
  localparam int TAG_W = 3;
`ifdef LAGARTO_FFLAGS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk;
  logic rstn;

  lagarto_fpu_fflags_acc_if #(.NUM_ENTRIES(8), .NUM_LANES(4)) bus ();

  lagarto_fpu_fflags_acc #(.NUM_ENTRIES(8), .NUM_LANES(4)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  typedef struct {
    int         id;
    logic [4:0] ff;
    logic [4:0] cf;
    logic       dirty;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   next_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [4:0] act, input logic [4:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s#%0d actual=%b required=%b", name, id, act, req);
    end
  endtask

  // Monitor: compares every commit report the DUT presents.
  always @(negedge clk) begin
    if (rstn && bus.commit_flags_valid_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_commit actual=%b required=none", bus.commit_flags_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("fflags", e.id, bus.fflags_o, e.ff);
        chk("commit_flags", e.id, bus.commit_flags_o, e.cf);
        chk("fs_dirty", e.id, {4'b0, bus.fs_dirty_o}, {4'b0, e.dirty});
        chk("err", e.id, {4'b0, bus.err_o}, {4'b0, e.err});
      end
    end
  end

  task automatic idle();
    bus.alloc_valid_i  = 1'b0;
    bus.alloc_tag_i    = '0;
    bus.rep_valid_i    = '0;
    bus.rep_tag_i      = '0;
    bus.rep_flags_i    = '0;
    bus.commit_valid_i = 1'b0;
    bus.commit_tag_i   = '0;
    bus.kill_valid_i   = 1'b0;
    bus.kill_tag_i     = '0;
    bus.flush_i        = 1'b0;
    bus.csr_we_i       = 1'b0;
    bus.csr_wdata_i    = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic set_alloc(input int t);
    bus.alloc_valid_i = 1'b1;
    bus.alloc_tag_i   = TAG_W'(t);
  endtask

  task automatic set_rep(input int lane, input int t, input logic [4:0] f);
    bus.rep_valid_i[lane]            = 1'b1;
    bus.rep_tag_i[lane*TAG_W +: TAG_W] = TAG_W'(t);
    bus.rep_flags_i[lane*5 +: 5]     = f;
  endtask

  task automatic set_kill(input int t);
    bus.kill_valid_i = 1'b1;
    bus.kill_tag_i   = TAG_W'(t);
  endtask

  task automatic set_csr(input logic [4:0] d);
    bus.csr_we_i    = 1'b1;
    bus.csr_wdata_i = d;
  endtask

  task automatic set_commit(input int t, input logic [4:0] ff, input logic [4:0] cf,
                            input logic dirty, input logic err);
    exp_t e;
    bus.commit_valid_i = 1'b1;
    bus.commit_tag_i   = TAG_W'(t);
    e.id = next_id; e.ff = ff; e.cf = cf; e.dirty = dirty; e.err = err;
    next_id++;
    exp_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_fflags"}, 0, bus.fflags_o, 5'b0);
    chk({name, "_cflags"}, 0, bus.commit_flags_o, 5'b0);
    chk({name, "_cvalid"}, 0, {4'b0, bus.commit_flags_valid_o}, 5'b0);
    chk({name, "_dirty"}, 0, {4'b0, bus.fs_dirty_o}, 5'b0);
    chk({name, "_err"}, 0, {4'b0, bus.err_o}, 5'b0);
  endtask

  initial begin
    idle();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2 chk_all_zero("reset");
    #9 rstn = 1'b1;
    step();

    // Two lanes reporting to one tag, then commit.
    set_alloc(3); step();
    set_rep(0, 3, 5'b00001); set_rep(2, 3, 5'b10000); step();
    set_commit(3, 5'b10001, 5'b10001, 1'b1, 1'b0); step();
    set_csr(5'b0); step();

    // Report bypass into a same-cycle commit.
    set_alloc(1); step();
    set_rep(1, 1, 5'b00100); set_commit(1, 5'b00100, 5'b00100, 1'b1, 1'b0); step();
    set_csr(5'b0); step();

    // Killed tag's flags never reach fflags.
    set_alloc(2); step();
    set_alloc(5); step();
    set_rep(3, 5, 5'b01000); step();
    set_kill(5); step();
    set_commit(2, 5'b00000, 5'b00000, 1'b0, 1'b0); step();

    // CSR write overrides same-cycle commit merge.
    set_csr(5'b00001); step();
    set_alloc(6); step();
    set_rep(0, 6, 5'b00010); step();
    set_csr(5'b11000); set_commit(6, 5'b11000, 5'b00010, 1'b1, 1'b0); step();

    // Commit with no reports leaves fflags alone.
    set_alloc(7); step();
    set_commit(7, 5'b11000, 5'b00000, 1'b0, 1'b0); step();

    // Commit and re-alloc of the same tag: second commit sees a clean entry.
    set_alloc(0); step();
    set_rep(0, 0, 5'b00001); step();
    set_alloc(0); set_commit(0, 5'b11001, 5'b00001, 1'b1, 1'b0); step();
    set_commit(0, 5'b11001, 5'b00000, 1'b0, 1'b0); step();

    // Fill all tags, flush with same-cycle alloc of tag 0.
    set_csr(5'b0); step();
    for (int i = 0; i < 8; i++) begin set_alloc(i); step(); end
    for (int k = 0; k < 4; k++) set_rep(k, k, 5'b11111);
    step();
    for (int k = 0; k < 4; k++) set_rep(k, k + 4, 5'b11111);
    step();
    bus.flush_i = 1'b1; set_alloc(0); set_rep(0, 0, 5'b10000); step();
    set_commit(0, 5'b00000, 5'b00000, 1'b0, 1'b0); step();
    set_commit(4, 5'b00000, 5'b00000, 1'b0, CHK); step();

    // Asynchronous reset with pending state.
    set_csr(5'b10101); step();
    set_alloc(2); step();
    set_rep(1, 2, 5'b11111); step();
    #3 rstn = 1'b0;
    #1 chk_all_zero("midreset");
    #2 rstn = 1'b1;
    step();
    set_commit(2, 5'b00000, 5'b00000, 1'b0, CHK); step();

    repeat (3) step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_commits actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lagarto_fpu_fflags_acc.md
# lagarto_fpu_fflags_acc

Consumer side of the FPU exception-flag path. Scalar and vector FP lanes produce per-operation flags {NV, DZ, OF, UF, NX}. This block collects those reports per in-flight instruction tag and holds them speculatively. On in-order commit it merges them into the architectural `fflags` field of `fcsr`; on squash it discards them. It sits between the FP functional-unit writeback ports and the CSR file / commit stage of the vector unit.

## Interface
- `NUM_ENTRIES`, 8: in-flight instruction tags tracked; power of two; `TAG_W = $clog2(NUM_ENTRIES)`.
- `NUM_LANES`, 4: flag report ports, one per FP lane.
- `clk_i`  in  1  core clock; all state updates on rising edge.
- `rstn_i`  in  1  reset, asynchronous, active-low.
- `alloc_valid_i`  in  1  allocate an entry for a newly issued FP instruction.
- `alloc_tag_i`  in  TAG_W  tag being allocated.
- `rep_valid_i`  in  NUM_LANES  per-lane flag report valid.
- `rep_tag_i`  in  NUM_LANES*TAG_W  per-lane report tag; lane k uses bits [k*TAG_W +: TAG_W].
- `rep_flags_i`  in  NUM_LANES*5  per-lane flags {NV,DZ,OF,UF,NX}; lane k uses bits [k*5 +: 5].
- `commit_valid_i`  in  1  instruction with `commit_tag_i` retires.
- `commit_tag_i`  in  TAG_W  retiring tag.
- `kill_valid_i`  in  1  squash a single tag.
- `kill_tag_i`  in  TAG_W  tag to squash.
- `flush_i`  in  1  invalidate all entries (pipeline flush).
- `csr_we_i`  in  1  software write of fflags.
- `csr_wdata_i`  in  5  fflags write data.
- `fflags_o`  out  5  architectural fflags.
- `commit_flags_valid_o`  out  1  registered: a commit completed last cycle.
- `commit_flags_o`  out  5  registered: flags of that committed instruction.
- `fs_dirty_o`  out  1  registered pulse: `fflags_o` changed value this cycle.
- `err_o`  out  1  sticky protocol error (see Configuration).

## Operation
- Per entry state: `valid` bit, 5-bit `pend` flags.
- Alloc: sets `valid`=1 and `pend`=0.
- Report: for each lane k with `rep_valid_i[k]`, OR `rep_flags_i` into `pend[rep_tag]`. Multiple lanes hitting the same tag in one cycle OR together.
- Commit: computes `cflags = pend[commit_tag] | (OR of same-cycle reports to commit_tag)`. Next cycle:
  - `fflags_o |= cflags`
  - entry `valid` cleared
  - `commit_flags_o = cflags`
  - `commit_flags_valid_o = 1`
- Kill: clears `valid` and `pend` of the tag. Same-cycle reports to that tag are dropped.
- Flush: clears every `valid` and `pend`. Same-cycle reports are dropped; same-cycle alloc still takes effect, so the new entry is valid.
- CSR write: `fflags_o <= csr_wdata_i`. It overrides a same-cycle commit merge, because the commit is program-order older. `commit_flags_*` still report the commit.
- `fs_dirty_o` pulses whenever the next `fflags_o` differs from the current value.
- Priority for the same tag in one cycle: flush > kill > commit > alloc. Alloc of a tag also committed or killed that cycle re-allocates it clean after the retire.

## Timing
- Reset values: all `valid`/`pend` = 0, `fflags_o` = 0, `commit_flags_valid_o` = 0, `commit_flags_o` = 0, `fs_dirty_o` = 0, `err_o` = 0.
- Report-to-fflags latency is 1 cycle when the report and the commit share a cycle; otherwise fflags update 1 cycle after commit.
- Commit has one retire per cycle, no backpressure. Commit of a tag with no reports yields `cflags` = 0 and leaves fflags unchanged.
- Reset asserted mid-operation clears all state asynchronously. Inputs are ignored while `rstn_i` = 0.

## Configuration
- `LAGARTO_FFLAGS_CHECK_EN` defined: `err_o` sets (sticky until reset) when any of these occur:
  - a report targets an invalid tag;
  - a commit or kill targets an invalid tag;
  - an alloc targets an already-valid tag not being retired that cycle.
  
  Offending reports are still dropped; offending allocs reinitialise the entry.
- Undefined: no checking logic; `err_o` is tied to 0. Functional behaviour is otherwise identical.

## Test plan
- Alloc tag 3; lane0 reports 5'b00001 and lane2 reports 5'b10000 to tag 3; commit tag 3 -> next cycle `fflags_o`=5'b10001, `commit_flags_o`=5'b10001, `commit_flags_valid_o`=1, `fs_dirty_o`=1.
- Alloc tag 1; lane1 reports 5'b00100 in the same cycle as commit tag 1 -> next cycle `fflags_o`=5'b00100 (bypass).
- Alloc tags 2 and 5; report 5'b01000 to tag 5; kill tag 5; commit tag 2 -> `fflags_o` stays 0, `commit_flags_o`=0, `fs_dirty_o`=0.
- `fflags_o`=5'b00001; commit tag with 5'b00010 and `csr_we_i` with 5'b11000 in the same cycle -> `fflags_o`=5'b11000, `commit_flags_o`=5'b00010.
- Fill all 8 tags with reports, assert `flush_i` with alloc tag 0, then commit tag 0 -> `fflags_o` unchanged. With the macro defined, a later commit of tag 4 sets `err_o`=1.
- Assert `rstn_i`=0 mid-stream with pending entries -> all outputs 0 immediately, and a post-reset commit of any tag merges 0.
